alu_bank_responder: RTL and testbench

- Responder side of the banked ALU command interface: accepts one command per bank via input_packet, executes on a single shared 32-bit add/sub unit, returns result and response per bank via output_packet.
- Arbitrates among pending banks.
- Sits between the command initiators (bench or upstream controllers) and downstream consumers of output_packet.

---
 rtl/alu_bank_responder_if.sv | 24 ++
 rtl/alu_bank_responder.sv | 139 +++++++++++++
 tb/tb_alu_bank_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_bank_responder_if.sv
// alu_bank_responder_if: command/response packet types and the banked packet bundle.
package alu_bank_responder_pkg;
   typedef enum logic [1:0] {NOP = 2'b00, ADD = 2'b01, SUB = 2'b10, INVALID = 2'b11} command_names_t;
   typedef enum logic [1:0] {NO_RESPONSE = 2'b00, SUCCESS = 2'b01, OVERFLOW = 2'b10, INVALID_COMMAND = 2'b11} response_names_t;
   typedef struct packed {
      command_names_t command;
      logic [31:0]    data1;
      logic [31:0]    data2;
   } input_packet_t;
   typedef struct packed {
      logic [31:0]     data;
      response_names_t response;
   } output_packet_t;
endpackage

interface alu_bank_responder_if #(
   parameter int NUM_BANKS = 4
);
   import alu_bank_responder_pkg::*;
   input_packet_t  input_packet  [NUM_BANKS];
   output_packet_t output_packet [NUM_BANKS];
   modport master (output input_packet, input output_packet);
   modport slave  (input input_packet, output output_packet);
endinterface

// File: rtl/alu_bank_responder.sv
// alu_bank_responder: per-bank command FSMs sharing one 32-bit add/sub unit.
// Define ALU_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module alu_bank_responder
   import alu_bank_responder_pkg::*;
#(
   parameter int NUM_BANKS = 4
) (
   input  logic                clock,
   input  logic                reset,
   alu_bank_responder_if.slave bus
);
   localparam int PW = $clog2(NUM_BANKS);
   typedef enum logic [1:0] {IDLE, PENDING, EXEC, RESP} state_t;
   state_t               r_state     [NUM_BANKS];
   state_t               w_state_nxt [NUM_BANKS];
   logic [NUM_BANKS-1:0] r_armed;
   logic [NUM_BANKS-1:0] w_accept;
   command_names_t       r_cmd [NUM_BANKS];
   logic [31:0]          r_d1  [NUM_BANKS];
   logic [31:0]          r_d2  [NUM_BANKS];
   logic                 w_gnt_vld;
   logic                 w_exec_vld;
   logic                 w_sub;
   logic                 w_ovf;
   logic [PW-1:0]        w_gnt;
   logic [PW-1:0]        w_exec;
   logic [31:0]          w_a;
   logic [31:0]          w_b;
   logic [31:0]          w_sum;
   logic [31:0]          r_alu_data;
   response_names_t      r_alu_rsp;

`ifdef ALU_FIXED_PRIORITY_EN
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      for (int k = NUM_BANKS - 1; k >= 0; k--) begin
         if (r_state[k] == PENDING) begin
            w_gnt_vld = 1'b1;
            w_gnt     = PW'(k);
         end
      end
   end
`else
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_cand;
   // Scan downward from the farthest candidate so the one nearest the pointer wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_cand    = '0;
      for (int k = NUM_BANKS - 1; k >= 0; k--) begin
         w_cand = PW'((int'(r_ptr) + k) % NUM_BANKS);
         if (r_state[w_cand] == PENDING) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_cand;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (!reset)
         r_ptr <= '0;
      else if (w_gnt_vld)
         r_ptr <= (w_gnt == PW'(NUM_BANKS - 1)) ? '0 : w_gnt + 1'b1;
   end
`endif

   always_comb begin
      for (int k = 0; k < NUM_BANKS; k++) begin
         w_state_nxt[k] = r_state[k];
         w_accept[k]    = r_state[k] == IDLE && r_armed[k] && bus.input_packet[k].command != NOP;
         case (r_state[k])
            IDLE:    w_state_nxt[k] = w_accept[k] ? PENDING : IDLE;
            PENDING: w_state_nxt[k] = (w_gnt_vld && w_gnt == PW'(k)) ? EXEC : PENDING;
            EXEC:    w_state_nxt[k] = RESP;
            default: w_state_nxt[k] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      for (int k = 0; k < NUM_BANKS; k++)
         r_state[k] <= !reset ? IDLE : w_state_nxt[k];
   end

   // At most one bank is in EXEC per cycle, so it alone drives the shared unit.
   always_comb begin
      w_exec_vld = 1'b0;
      w_exec     = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (r_state[k] == EXEC) begin
            w_exec_vld = 1'b1;
            w_exec     = PW'(k);
         end
      end
   end

   assign w_a   = r_d1[w_exec];
   assign w_b   = r_d2[w_exec];
   assign w_sub = r_cmd[w_exec] == SUB;
   assign w_sum = w_sub ? w_a - w_b : w_a + w_b;
   assign w_ovf = (w_a[31] == (w_b[31] ^ w_sub)) && (w_sum[31] != w_a[31]);

   always_ff @(posedge clock) begin
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (w_accept[k]) begin
            r_cmd[k] <= bus.input_packet[k].command;
            r_d1[k]  <= bus.input_packet[k].data1;
            r_d2[k]  <= bus.input_packet[k].data2;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_armed    <= '1;
         r_alu_data <= '0;
         r_alu_rsp  <= NO_RESPONSE;
         for (int k = 0; k < NUM_BANKS; k++) begin
            bus.output_packet[k].data     <= '0;
            bus.output_packet[k].response <= NO_RESPONSE;
         end
      end else begin
         for (int k = 0; k < NUM_BANKS; k++) begin
            if (bus.input_packet[k].command == NOP)
               r_armed[k] <= 1'b1;
            else if (w_accept[k])
               r_armed[k] <= 1'b0;
            bus.output_packet[k].response <= (r_state[k] == RESP) ? r_alu_rsp : NO_RESPONSE;
            if (r_state[k] == RESP && r_alu_rsp != INVALID_COMMAND)
               bus.output_packet[k].data <= r_alu_data;
         end
         if (w_exec_vld) begin
            r_alu_data <= w_sum;
            r_alu_rsp  <= (r_cmd[w_exec] == INVALID) ? INVALID_COMMAND : w_ovf ? OVERFLOW : SUCCESS;
         end
      end
   end
endmodule

// File: tb/tb_alu_bank_responder.sv
// tb_alu_bank_responder: directed stimulus with a queue-based response scoreboard.
module tb_alu_bank_responder;
   import alu_bank_responder_pkg::*;
   localparam int NB = 4;
   typedef struct {
      int              bank;
      logic [31:0]     data;
      response_names_t rsp;
      int              cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];

   alu_bank_responder_if #(.NUM_BANKS(NB)) bus ();
   alu_bank_responder #(.NUM_BANKS(NB)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic drive(int b, command_names_t c, logic [31:0] a, logic [31:0] d);
      bus.input_packet[b] = '{command: c, data1: a, data2: d};
   endtask

   task automatic nop_all();
      for (int b = 0; b < NB; b++) drive(b, NOP, '0, '0);
   endtask

   task automatic expect_rsp(int b, logic [31:0] d, response_names_t r, int lat);
      q.push_back('{bank: b, data: d, rsp: r, cyc: cyc + lat});
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check_outputs(string name, logic [31:0] d [NB]);
      for (int b = 0; b < NB; b++) begin
         check($sformatf("%s_data%0d", name, b), bus.output_packet[b].data, d[b]);
         check($sformatf("%s_rsp%0d", name, b), 32'(bus.output_packet[b].response), 32'(NO_RESPONSE));
      end
   endtask

   task automatic op(int b, command_names_t c, logic [31:0] a, logic [31:0] d,
                     logic [31:0] ed, response_names_t er);
      drive(b, c, a, d);
      expect_rsp(b, ed, er, 4);
      idle(1);
      drive(b, NOP, '0, '0);
      idle(5);
   endtask

   always @(negedge clock) begin
      exp_t e;
      for (int b = 0; b < NB; b++) begin
         if (cyc > 0 && bus.output_packet[b].response != NO_RESPONSE) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: bank %0d response %0d data %h at cycle %0d, none expected",
                        b, bus.output_packet[b].response, bus.output_packet[b].data, cyc);
            end else begin
               e = q.pop_front();
               check("rsp_bank", 32'(b), 32'(e.bank));
               check("rsp_cycle", 32'(cyc), 32'(e.cyc));
               check("rsp_data", bus.output_packet[b].data, e.data);
               check("rsp_code", 32'(bus.output_packet[b].response), 32'(e.rsp));
            end
         end
      end
   end

   initial begin
      logic [31:0] zeros [NB];
      logic [31:0] held  [NB];
      zeros = '{default: '0};
      nop_all();
      reset = 1'b0;
      idle(2);
      check_outputs("in_reset", zeros);
      reset = 1'b1;
      idle(1);
      check_outputs("after_reset", zeros);

      // held ADD executes once; re-arm only after NOP
      drive(0, ADD, 32'h0000_0005, 32'h0000_0003);
      expect_rsp(0, 32'h0000_0008, SUCCESS, 4);
      idle(5);
      drive(0, NOP, '0, '0);
      idle(3);
      check("b0_hold_data", bus.output_packet[0].data, 32'h0000_0008);

      op(1, SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, SUCCESS);
      op(1, ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, OVERFLOW);
      op(1, SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, OVERFLOW);
      op(2, ADD, 32'h0000_0004, 32'h0000_0004, 32'h0000_0008, SUCCESS);
      op(2, INVALID, 32'h1234_5678, 32'h1111_1111, 32'h0000_0008, INVALID_COMMAND);
      check("b2_inv_data", bus.output_packet[2].data, 32'h0000_0008);
      check("b2_inv_clear", 32'(bus.output_packet[2].response), 32'(NO_RESPONSE));
      op(3, ADD, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, SUCCESS);

      // pointer is back at 0: all four banks served in index order
      for (int b = 0; b < NB; b++) begin
         drive(b, ADD, 32'(b), 32'h0000_0100);
         expect_rsp(b, 32'h0000_0100 + 32'(b), SUCCESS, 4 + b);
      end
      idle(1);
      nop_all();
      idle(8);

      drive(3, ADD, 32'h0000_0030, 32'h0000_0001);
      drive(0, ADD, 32'h0000_0040, 32'h0000_0002);
      expect_rsp(0, 32'h0000_0042, SUCCESS, 4);
      expect_rsp(3, 32'h0000_0031, SUCCESS, 5);
      idle(1);
      nop_all();
      idle(7);

      // after a lone bank-1 grant the pointer sits at 2
      op(1, ADD, 32'h0000_0010, 32'h0000_0010, 32'h0000_0020, SUCCESS);
      drive(0, SUB, 32'h0000_0009, 32'h0000_0002);
      drive(2, ADD, 32'h0000_0009, 32'h0000_0002);
`ifdef ALU_FIXED_PRIORITY_EN
      expect_rsp(0, 32'h0000_0007, SUCCESS, 4);
      expect_rsp(2, 32'h0000_000B, SUCCESS, 5);
`else
      expect_rsp(2, 32'h0000_000B, SUCCESS, 4);
      expect_rsp(0, 32'h0000_0007, SUCCESS, 5);
`endif
      idle(1);
      nop_all();
      idle(7);

      // reset while banks 1 and 3 are pending: no responses, outputs cleared
      held = '{32'h0000_0007, 32'h0000_0020, 32'h0000_000B, 32'h0000_0031};
      check_outputs("pre_reset", held);
      drive(1, ADD, 32'h0000_0001, 32'h0000_0001);
      drive(3, SUB, 32'h0000_0005, 32'h0000_0001);
      idle(1);
      reset = 1'b0;
      nop_all();
      idle(1);
      check_outputs("mid_reset", zeros);
      reset = 1'b1;
      idle(1);
      check_outputs("post_reset", zeros);
      op(0, ADD, 32'h0000_000A, 32'h0000_0014, 32'h0000_001E, SUCCESS);
      idle(5);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_rsp: %0d responses outstanding, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
